// File: rtl/write_fsm_if.sv
// Bundle between the memory stage, the write-back FSM and the register bank.
// master: drives IR/PC/ALU_in/MEM_*; slave: the FSM (WB_*, LOAD_ERR, ready_out).
interface write_fsm_if;
    logic [31:0] IR;
    logic [31:0] PC;
    logic [31:0] ALU_in;
    logic [31:0] MEM_data;
    logic        MEM_valid;
    logic        valid_in;
    logic        ready_out;
    logic [4:0]  WB_address;
    logic [31:0] WB_data;
    logic        WB_en;
    logic        LOAD_ERR;
`ifdef WB_BYPASS_EN
    logic        BYP_valid;
    logic [4:0]  BYP_address;
    logic [31:0] BYP_data;
`endif

    modport master (
        output IR, PC, ALU_in, MEM_data, MEM_valid, valid_in,
        input  ready_out, WB_address, WB_data, WB_en, LOAD_ERR
`ifdef WB_BYPASS_EN
        , input BYP_valid, BYP_address, BYP_data
`endif
    );

    modport slave (
        input  IR, PC, ALU_in, MEM_data, MEM_valid, valid_in,
        output ready_out, WB_address, WB_data, WB_en, LOAD_ERR
`ifdef WB_BYPASS_EN
        , output BYP_valid, BYP_address, BYP_data
`endif
    );
endinterface

// File: rtl/write_fsm.sv
// Write-back FSM: retires one instruction per accept, waits for load data
// (16-cycle timeout -> sticky LOAD_ERR) and emits a one-cycle WB_en strobe.
// Ports: clk, rst (sync, active-high), bus (write_fsm_if.slave).
// Optional macro WB_BYPASS_EN adds BYP_valid/BYP_address/BYP_data holding
// the last committed write.
module write_fsm (
    input  logic       clk,
    input  logic       rst,
    write_fsm_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD_WAIT, WRITE} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [4:0]  rd_q, rd_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic        accept;
    logic        is_load;
    logic        is_alu;
    logic        is_link;
    logic        wb_en;
    logic        unused_ir;

    assign opcode    = bus.IR[6:0];
    assign rd        = bus.IR[11:7];
    assign unused_ir = ^bus.IR[31:15];

    assign is_load = (opcode == 7'b0000011);
    assign is_alu  = (opcode == 7'b0110011) || (opcode == 7'b0010011) ||
                     (opcode == 7'b0110111) || (opcode == 7'b0010111);
    assign is_link = (opcode == 7'b1101111) || (opcode == 7'b1100111);

    assign bus.ready_out = (state_q != LOAD_WAIT);
    assign accept        = bus.valid_in && bus.ready_out;

    // Byte/halfword lane select and extension of the aligned load word.
    function automatic logic [31:0] load_ext(input logic [31:0] w,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  off);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = w >> {off, 3'b000};
        b  = sh[7:0];
        h  = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b100:  load_ext = {24'd0, b};
            3'b101:  load_ext = {16'd0, h};
            default: load_ext = w;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rd_d    = rd_q;
        f3_d    = f3_q;
        off_d   = off_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            LOAD_WAIT: begin
                if (bus.MEM_valid) begin
                    waddr_d = rd_q;
                    wdata_d = load_ext(bus.MEM_data, f3_q, off_q);
                    // x0 loads complete the wait but never write
                    state_d = (rd_q != 5'd0) ? WRITE : IDLE;
                end else if (cnt_q == 4'd15) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                // IDLE and WRITE both accept; WRITE overlaps the next accept
                state_d = IDLE;
                if (accept) begin
                    if (is_load) begin
                        state_d = LOAD_WAIT;
                        rd_d    = rd;
                        f3_d    = bus.IR[14:12];
                        off_d   = bus.ALU_in[1:0];
                        cnt_d   = 4'd0;
                    end else if ((is_alu || is_link) && rd != 5'd0) begin
                        state_d = WRITE;
                        waddr_d = rd;
                        wdata_d = is_link ? bus.PC + 32'd4 : bus.ALU_in;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            rd_q    <= 5'd0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            waddr_q <= 5'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // rst during WRITE suppresses the strobe of that same cycle
    assign wb_en          = (state_q == WRITE) && !rst;
    assign bus.WB_en      = wb_en;
    assign bus.WB_address = wb_en ? waddr_q : 5'd0;
    assign bus.WB_data    = wb_en ? wdata_q : 32'd0;
    assign bus.LOAD_ERR   = err_q;

`ifdef WB_BYPASS_EN
    logic        byp_valid_q;
    logic [4:0]  byp_addr_q;
    logic [31:0] byp_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            byp_valid_q <= 1'b0;
            byp_addr_q  <= 5'd0;
            byp_data_q  <= 32'd0;
        end else if (wb_en) begin
            byp_valid_q <= 1'b1;
            byp_addr_q  <= waddr_q;
            byp_data_q  <= wdata_q;
        end
    end

    assign bus.BYP_valid   = byp_valid_q;
    assign bus.BYP_address = byp_addr_q;
    assign bus.BYP_data    = byp_data_q;
`endif
endmodule

// File: tb/tb_write_fsm.sv
// Self-checking bench for write_fsm: scoreboard of expected writes
// plus per-scenario inline checks.
module tb_write_fsm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;
    bit   mon_on = 1'b0;
    logic [36:0] q[$];

    write_fsm_if bus();
    write_fsm dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Scoreboard: every WB_en pulse must match the next expected write;
    // with WB_en low the address/data must be zero.
    always @(negedge clk) begin
        if (mon_on) begin
            total++;
            if (bus.WB_en === 1'b1) begin
                if (q.size() == 0) begin
                    $display("FAIL sb_unexpected: got addr=%0d data=%h, required no write",
                             bus.WB_address, bus.WB_data);
                end else begin
                    logic [36:0] e;
                    e = q.pop_front();
                    if ({bus.WB_address, bus.WB_data} !== e)
                        $display("FAIL sb_write: got %0d/%h, required %0d/%h",
                                 bus.WB_address, bus.WB_data, e[36:32], e[31:0]);
                    else passed++;
                end
            end else if (bus.WB_en !== 1'b0 || bus.WB_address !== 5'd0 ||
                         bus.WB_data !== 32'd0) begin
                $display("FAIL sb_idle: got en=%b addr=%0d data=%h, required 0/0/0",
                         bus.WB_en, bus.WB_address, bus.WB_data);
            end else passed++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ir, input logic [31:0] pc,
                         input logic [31:0] alu);
        bus.IR = ir;
        bus.PC = pc;
        bus.ALU_in = alu;
        bus.valid_in = 1'b1;
        cyc();
        bus.valid_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        total++;
        if (bus.ready_out !== 1'b1 || bus.WB_en !== 1'b0 ||
            bus.WB_address !== 5'd0 || bus.WB_data !== 32'd0 ||
            bus.LOAD_ERR !== 1'b0)
            $display("FAIL reset: got rdy=%b en=%b a=%0d d=%h err=%b, required 1/0/0/0/0",
                     bus.ready_out, bus.WB_en, bus.WB_address, bus.WB_data, bus.LOAD_ERR);
        else passed++;
        rst = 1'b0;
        mon_on = 1'b1;
    endtask

    task automatic test_addi();
        q.push_back({5'd5, 32'h0000_002A});
        issue(32'h02A0_0293, 32'h0000_0100, 32'h0000_002A);
        total++;
        if (bus.WB_en !== 1'b1 || bus.WB_address !== 5'd5 || bus.WB_data !== 32'h2A)
            $display("FAIL addi_wb: got en=%b a=%0d d=%h, required 1/5/0000002a",
                     bus.WB_en, bus.WB_address, bus.WB_data);
        else passed++;
        cyc();
        total++;
        if (bus.WB_en !== 1'b0 || bus.WB_address !== 5'd0 || bus.WB_data !== 32'd0)
            $display("FAIL addi_after: got en=%b a=%0d d=%h, required 0/0/0",
                     bus.WB_en, bus.WB_address, bus.WB_data);
        else passed++;
    endtask

    task automatic test_lb_wait();
        q.push_back({5'd7, 32'hFFFF_FF80});
        bus.MEM_valid = 1'b1;
        bus.MEM_data = 32'hDEAD_BEEF;
        issue(32'h0000_0383, 32'h0000_0200, 32'h0000_1002);
        bus.MEM_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                bus.MEM_valid = 1'b1;
                bus.MEM_data = 32'h0080_0000;
            end
            total++;
            if (bus.ready_out !== 1'b0 || bus.WB_en !== 1'b0)
                $display("FAIL lb_wait%0d: got rdy=%b en=%b, required 0/0",
                         i, bus.ready_out, bus.WB_en);
            else passed++;
            cyc();
        end
        bus.MEM_valid = 1'b0;
        total++;
        if (bus.WB_en !== 1'b1 || bus.WB_address !== 5'd7 ||
            bus.WB_data !== 32'hFFFF_FF80)
            $display("FAIL lb_wb: got en=%b a=%0d d=%h, required 1/7/ffffff80",
                     bus.WB_en, bus.WB_address, bus.WB_data);
        else passed++;
        cyc();
    endtask

    task automatic test_load_formats();
        logic [2:0]  f3 [11] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b010, 3'b100,
                                 3'b100, 3'b101, 3'b101, 3'b011, 3'b000};
        logic [1:0]  off[11] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd3,
                                 2'd2, 2'd2, 2'd0, 2'd3, 2'd2};
        logic [31:0] ex [11] = '{32'hFFFF_FFA1, 32'hFFFF_FFF0, 32'hFFFF_F0A1,
                                 32'hFFFF_8765, 32'h8765_F0A1, 32'h0000_0087,
                                 32'h0000_0065, 32'h0000_8765, 32'h0000_F0A1,
                                 32'h8765_F0A1, 32'h0000_0065};
        for (int i = 0; i < 11; i++) begin
            logic [4:0] r;
            r = 5'(10 + i);
            q.push_back({r, ex[i]});
            issue({17'd0, f3[i], r, 7'b0000011}, 32'h0, {30'h800, off[i]});
            bus.MEM_valid = 1'b1;
            bus.MEM_data = 32'h8765_F0A1;
            cyc();
            bus.MEM_valid = 1'b0;
            cyc();
        end
        // x0 load waits for data but never writes
        issue(32'h0000_2003, 32'h0, 32'h0);
        total++;
        if (bus.ready_out !== 1'b0)
            $display("FAIL ld_x0_wait: got rdy=%b, required 0", bus.ready_out);
        else passed++;
        bus.MEM_valid = 1'b1;
        cyc();
        bus.MEM_valid = 1'b0;
        cyc();
        total++;
        if (q.size() != 0)
            $display("FAIL ld_formats_drain: got %0d pending, required 0", q.size());
        else passed++;
    endtask

    task automatic test_opcodes();
        logic [31:0] ir [8] = '{32'h0000_00EF, 32'h0000_0067, 32'h0000_04E7,
                                32'h1234_5337, 32'h0000_0397, 32'h0062_8463,
                                32'h0000_000F, 32'h0000_0033};
        logic [31:0] pc [8] = '{32'hFFFF_FFFC, 32'h0000_0100, 32'h0000_1000,
                                32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        logic        wr [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [4:0]  ad [8] = '{5'd1, 5'd0, 5'd9, 5'd6, 5'd7, 5'd0, 5'd0, 5'd0};
        logic [31:0] dt [8] = '{32'h0, 32'h0, 32'h0000_1004, 32'h1234_5000,
                                32'h0000_0ABC, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 8; i++) begin
            if (wr[i]) q.push_back({ad[i], dt[i]});
            issue(ir[i], pc[i], (i == 3) ? 32'h1234_5000 : 32'h0000_0ABC);
            total++;
            if (bus.WB_en !== wr[i] || bus.WB_address !== ad[i] ||
                bus.WB_data !== dt[i])
                $display("FAIL opcode%0d: got en=%b a=%0d d=%h, required %b/%0d/%h",
                         i, bus.WB_en, bus.WB_address, bus.WB_data, wr[i], ad[i], dt[i]);
            else passed++;
            cyc();
        end
    endtask

    task automatic test_back_to_back();
        q.push_back({5'd3, 32'h0000_0111});
        q.push_back({5'd4, 32'h0000_0222});
        bus.IR = 32'h0000_01B3;
        bus.ALU_in = 32'h111;
        bus.valid_in = 1'b1;
        cyc();
        total++;
        if (bus.WB_en !== 1'b1 || bus.WB_address !== 5'd3 || bus.ready_out !== 1'b1)
            $display("FAIL b2b_first: got en=%b a=%0d rdy=%b, required 1/3/1",
                     bus.WB_en, bus.WB_address, bus.ready_out);
        else passed++;
        bus.IR = 32'h0000_0233;
        bus.ALU_in = 32'h222;
        cyc();
        bus.valid_in = 1'b0;
        total++;
        if (bus.WB_en !== 1'b1 || bus.WB_address !== 5'd4 || bus.WB_data !== 32'h222)
            $display("FAIL b2b_second: got en=%b a=%0d d=%h, required 1/4/00000222",
                     bus.WB_en, bus.WB_address, bus.WB_data);
        else passed++;
        cyc();
        total++;
        if (bus.WB_en !== 1'b0)
            $display("FAIL b2b_end: got en=%b, required 0", bus.WB_en);
        else passed++;
    endtask

    task automatic test_store();
        issue(32'h0062_A423, 32'h0, 32'h0000_1000);
        total++;
        if (bus.WB_en !== 1'b0 || bus.ready_out !== 1'b1)
            $display("FAIL store: got en=%b rdy=%b, required 0/1",
                     bus.WB_en, bus.ready_out);
        else passed++;
        cyc();
    endtask

    task automatic test_rst_cancel();
        issue(32'h0000_2483, 32'h0, 32'h0000_3000);
        cyc();
        rst = 1'b1;
        bus.MEM_valid = 1'b1;
        bus.MEM_data = 32'h5555_AAAA;
        cyc();
        rst = 1'b0;
        bus.MEM_valid = 1'b0;
        total++;
        if (bus.ready_out !== 1'b1 || bus.WB_en !== 1'b0)
            $display("FAIL rst_load: got rdy=%b en=%b, required 1/0",
                     bus.ready_out, bus.WB_en);
        else passed++;
        cyc();
        cyc();
        issue(32'h02A0_0293, 32'h0, 32'h0000_002A);
        rst = 1'b1;
        #1;
        total++;
        if (bus.WB_en !== 1'b0)
            $display("FAIL rst_write: got en=%b, required 0", bus.WB_en);
        else passed++;
        cyc();
        rst = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_timeout();
        q.push_back({5'd8, 32'h1234_5678});
        issue(32'h0000_2403, 32'h0, 32'h0000_4000);
        for (int i = 0; i < 15; i++) cyc();
        bus.MEM_valid = 1'b1;
        bus.MEM_data = 32'h1234_5678;
        cyc();
        bus.MEM_valid = 1'b0;
        total++;
        if (bus.WB_en !== 1'b1 || bus.LOAD_ERR !== 1'b0)
            $display("FAIL to_last_cycle: got en=%b err=%b, required 1/0",
                     bus.WB_en, bus.LOAD_ERR);
        else passed++;
        cyc();
        issue(32'h0000_2403, 32'h0, 32'h0000_4000);
        for (int i = 0; i < 16; i++) begin
            total++;
            if (bus.ready_out !== 1'b0 || bus.LOAD_ERR !== 1'b0)
                $display("FAIL to_wait%0d: got rdy=%b err=%b, required 0/0",
                         i, bus.ready_out, bus.LOAD_ERR);
            else passed++;
            cyc();
        end
        total++;
        if (bus.LOAD_ERR !== 1'b1 || bus.ready_out !== 1'b1 || bus.WB_en !== 1'b0)
            $display("FAIL timeout: got err=%b rdy=%b en=%b, required 1/1/0",
                     bus.LOAD_ERR, bus.ready_out, bus.WB_en);
        else passed++;
        bus.MEM_valid = 1'b1;
        cyc();
        bus.MEM_valid = 1'b0;
        q.push_back({5'd5, 32'h0000_0001});
        issue(32'h0010_0293, 32'h0, 32'h0000_0001);
        cyc();
        total++;
        if (bus.LOAD_ERR !== 1'b1)
            $display("FAIL err_sticky: got %b, required 1", bus.LOAD_ERR);
        else passed++;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        total++;
        if (bus.LOAD_ERR !== 1'b0)
            $display("FAIL err_clear: got %b, required 0", bus.LOAD_ERR);
        else passed++;
    endtask

    initial begin
        bus.IR = 32'd0;
        bus.PC = 32'd0;
        bus.ALU_in = 32'd0;
        bus.MEM_data = 32'd0;
        bus.MEM_valid = 1'b0;
        bus.valid_in = 1'b0;
        test_reset();
        test_addi();
        test_lb_wait();
        test_load_formats();
        test_opcodes();
        test_back_to_back();
        test_store();
        test_rst_cancel();
        test_timeout();
        cyc();
        cyc();
        mon_on = 1'b0;
        total++;
        if (q.size() != 0)
            $display("FAIL sb_drain: got %0d pending, required 0", q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/write_fsm.md
WRITE_FSM -- requirements
Module: WRITE_FSM

Interface
REQ-001 SHALL: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL: IR  in  32  instruction retiring from memory stage.
REQ-004 SHALL: PC  in  32  PC of that instruction.
REQ-005 SHALL: ALU_in  in  32  ALU result or effective load address.
REQ-006 SHALL: MEM_data  in  32  aligned load word from data memory.
REQ-007 SHALL: MEM_valid  in  1  MEM_data valid this cycle.
REQ-008 SHALL: valid_in  in  1  IR/PC/ALU_in valid this cycle.
REQ-009 SHALL: ready_out  out  1  stage accepts an instruction this cycle.
REQ-010 SHALL: WB_address  out  5  register-file write index, feeds the decode-stage register bank.
REQ-011 SHALL: WB_data  out  32  register-file write data.
REQ-012 SHALL: WB_en  out  1  write strobe, one cycle per committed write.
REQ-013 SHALL: LOAD_ERR  out  1  sticky load-timeout flag.

Function
REQ-014 SHALL: FSM states IDLE, LOAD_WAIT, WRITE; ready_out = 1 in IDLE and WRITE, 0 in LOAD_WAIT.
REQ-015 SHALL: accept when valid_in && ready_out; opcode = IR[6:0], rd = IR[11:7], funct3 = IR[14:12] captured on accept.
REQ-016 SHALL: accepted opcode 0000011 (load) -> LOAD_WAIT; other writing opcode with rd != 0 -> WRITE next cycle; no-write instruction -> IDLE.
REQ-017 SHALL: writing opcodes 0110011, 0010011, 0110111, 0010111 select ALU_in; 1101111, 1100111 select PC+4 modulo 2^32; 0000011 selects load data.
REQ-018 SHALL: opcodes 1100011, 0100011 and all unlisted opcodes retire with no write.
REQ-019 SHALL: rd == 0 never asserts WB_en; the instruction still retires, loads still wait for MEM_valid.
REQ-020 SHALL: load data from MEM_data by funct3 and ALU_in[1:0]: 000 sign-extended byte lane, 001 sign-extended halfword at ALU_in[1], 010 full word, 100 zero-extended byte, 101 zero-extended halfword, others full word.
REQ-021 SHALL: MEM_valid sampled only in LOAD_WAIT; on MEM_valid capture data -> WRITE; ignored in IDLE/WRITE and in the accept cycle.
REQ-022 SHALL: LOAD_WAIT counter 0..15; MEM_valid not seen by 16th LOAD_WAIT cycle -> set LOAD_ERR, no write, -> IDLE.
REQ-023 SHALL: WRITE state asserts WB_en exactly one cycle with registered WB_address/WB_data; accept in WRITE overlaps, giving back-to-back writes.
REQ-024 SHALL: WB_en = 0 forces WB_address = 0 and WB_data = 0, so an always-enabled register bank only writes x0.
REQ-025 SHALL: latency accept -> WB_en: 1 cycle non-load; load: cycles until MEM_valid plus 1.

Reset
REQ-026 SHALL: rst -> IDLE, counter 0, LOAD_ERR 0, WB_en 0, WB_address 0, WB_data 0, ready_out 1 in the following cycle.
REQ-027 SHALL: rst mid-LOAD_WAIT or in WRITE cancels the pending write; no WB_en follows.
REQ-028 SHALL: LOAD_ERR cleared only by rst.

Configuration
REQ-029 SHALL: macro WB_BYPASS_EN defined -> outputs BYP_valid (1), BYP_address (5), BYP_data (32) hold the last committed write from the cycle after WB_en until the next write, cleared by rst; undefined -> ports and registers absent, other behaviour identical.

Verification
REQ-030 SHALL: accept ADDI x5, ALU_in=0x0000_002A -> next cycle WB_en=1, WB_address=5, WB_data=0x2A, then WB_en=0 with address/data 0.
REQ-031 SHALL: LB x7, ALU_in[1:0]=2, MEM_data=0x0080_0000 after 3 wait cycles -> ready_out=0 while waiting, then WB_data=0xFFFF_FF80, WB_address=7.
REQ-032 SHALL: JAL x1, PC=0xFFFF_FFFC -> WB_data=0x0000_0000; JALR x0 -> no WB_en.
REQ-033 SHALL: LW with no MEM_valid for 16 cycles -> LOAD_ERR=1, no WB_en, ready_out=1; rst -> LOAD_ERR=0.
REQ-034 SHALL: back-to-back ADD x3, ADD x4 on consecutive cycles -> two consecutive WB_en pulses; rst asserted in LOAD_WAIT -> no write; SW -> no write.
